// File: rtl/circ_shift_sched_pkg.sv
// Shared ECC definitions for the circular shift scheduler and its shifter.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package circ_shift_sched_pkg;

    localparam int FIELD_W       = 163;
    localparam int SHAMT_W       = 7;
    localparam int AMT_W         = 8;
    localparam int FIELD_MOD_AMT = 163;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Requested amounts are 0..255, so a single conditional subtract
    // brings any of them into 0..162.
    function automatic logic [AMT_W-1:0] amt_mod_field(input logic [AMT_W-1:0] amt);
        logic [AMT_W-1:0] w_mod;
        w_mod = AMT_W'(FIELD_MOD_AMT);
        return (amt >= w_mod) ? (amt - w_mod) : amt;
    endfunction

endpackage

// File: rtl/circ_leftshift_163b.sv
// Combinational 163-bit circular left shifter (bit i -> bit (i+shamt) mod 163).
// Latency: 0 cycles. Backpressure: none, pure logic.
// Ports: i_data operand, i_shamt rotate amount 0..127, o_data rotated result.
module circ_leftshift_163b
    import circ_shift_sched_pkg::*;
(
    input  logic [FIELD_W-1:0] i_data,
    input  logic [SHAMT_W-1:0] i_shamt,
    output logic [FIELD_W-1:0] o_data
);

    logic [2*FIELD_W-1:0] w_dbl;

    // Shifting two back-to-back copies left and keeping the upper half
    // wraps the bits that fall off the top back into the bottom.
    always_comb begin
        w_dbl  = {i_data, i_data} << i_shamt;
        o_data = w_dbl[2*FIELD_W-1:FIELD_W];
    end

endmodule

// File: rtl/circ_shift_sched.sv
// Round-robin front end for the shared 163-bit rotator: accepts one request,
// rotates it by (amt mod 163) in passes of at most STEP_MAX bits per cycle.
// Latency: 1 + ceil(amt_mod/STEP_MAX) cycles from accept to resp_valid (1 when amt_mod==0).
// Backpressure: result held in DONE until resp_ready; requests wait (ready=0) unless IDLE.
// Ports: clk/rst (sync, active-high); req0_*/req1_* valid/ready request channels
// carrying operand and 8-bit amount; resp_* valid/ready response with owner id; busy.
module circ_shift_sched
    import circ_shift_sched_pkg::*;
#(
    parameter int W        = FIELD_W,
    parameter int SW       = SHAMT_W,
    parameter int STEP_MAX = 127
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [W-1:0]     req0_data,
    input  logic [AMT_W-1:0] req0_amt,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [W-1:0]     req1_data,
    input  logic [AMT_W-1:0] req1_amt,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [W-1:0]     resp_data,
    output logic             busy
);

    localparam logic [AMT_W-1:0] STEP_LIM = AMT_W'(STEP_MAX);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [W-1:0]     r_data;
    logic [AMT_W-1:0] r_rem;
    logic             r_id;
    logic             r_last_grant;

    logic             w_grant0;
    logic             w_grant1;
    logic             w_accept;
    logic [AMT_W-1:0] w_amt_sel;
    logic [AMT_W-1:0] w_amt_mod;
    logic [W-1:0]     w_data_sel;
    logic [SW-1:0]    w_step;
    logic [W-1:0]     w_rot;

    // Arbiter: a lone valid port wins; on contention the port that did not
    // win last time goes first. Only offered while idle and out of reset.
    always_comb begin
        w_grant0   = (r_state == IDLE) && !rst && req0_valid && (!req1_valid || r_last_grant);
        w_grant1   = (r_state == IDLE) && !rst && req1_valid && (!req0_valid || !r_last_grant);
        w_accept   = w_grant0 || w_grant1;
        w_amt_sel  = w_grant1 ? req1_amt  : req0_amt;
        w_data_sel = w_grant1 ? req1_data : req0_data;
        w_amt_mod  = amt_mod_field(w_amt_sel);
    end

    // Pass size: the whole remainder if it fits, otherwise a full STEP_MAX pass.
    always_comb begin
        w_step = (r_rem > STEP_LIM) ? SW'(STEP_MAX) : r_rem[SW-1:0];
    end

    circ_leftshift_163b u_shift (
        .i_data  (r_data),
        .i_shamt (w_step),
        .o_data  (w_rot)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (w_amt_mod == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (r_rem == AMT_W'(w_step)) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (resp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Datapath: operand is captured at accept and only rotated in RUN, so it
    // holds steady through DONE and keeps the last result afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data       <= '0;
            r_rem        <= '0;
            r_id         <= 1'b0;
            r_last_grant <= 1'b1;
        end else if (w_accept) begin
            r_data       <= w_data_sel;
            r_rem        <= w_amt_mod;
            r_id         <= w_grant1;
            r_last_grant <= w_grant1;
        end else if (r_state == RUN) begin
            r_data       <= w_rot;
            r_rem        <= r_rem - AMT_W'(w_step);
        end
    end

    always_comb begin
        req0_ready = w_grant0;
        req1_ready = w_grant1;
        resp_valid = (r_state == DONE);
        resp_id    = r_id;
        resp_data  = r_data;
        busy       = (r_state != IDLE);
    end

endmodule
